// File: rtl/rv_div.sv
// Iterative RISC-V M-extension divider: one quotient bit per cycle,
// with divide-by-zero and signed-overflow results resolved in PREP.
module rv_div #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            div_valid_i,
    output logic            div_ready_o,
    input  logic [1:0]      div_op_i,
    input  logic [XLEN-1:0] div_op1_i,
    input  logic [XLEN-1:0] div_op2_i,
    input  logic            flush_i,
    output logic            res_valid_o,
    input  logic            res_ready_i,
    output logic [XLEN-1:0] res_o
);
    localparam int CW = $clog2(XLEN + 1);

    typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} state_t;

    state_t          state;
    logic [1:0]      op;
    logic [XLEN-1:0] op1, op2;
    logic [XLEN-1:0] dvd;        // dividend shifts out MSB-first, quotient shifts in
    logic [XLEN-1:0] dvs;
    logic [XLEN-1:0] rem;
    logic [CW-1:0]   cnt;
    logic            q_neg, r_neg;

    // op[0]=1 marks unsigned ops, op[1]=1 selects remainder
    logic            is_signed;
    logic            div_zero, sgn_ovf;
    logic [XLEN-1:0] abs1, abs2;
    logic [XLEN:0]   shifted, diff;
    logic [XLEN-1:0] q_fix, r_fix;

    always_comb begin
        is_signed = ~op[0];
        div_zero  = (op2 == '0);
        sgn_ovf   = is_signed && (op1 == {1'b1, {(XLEN-1){1'b0}}}) && (op2 == '1);
        abs1      = (is_signed && op1[XLEN-1]) ? -op1 : op1;
        abs2      = (is_signed && op2[XLEN-1]) ? -op2 : op2;
        shifted   = {rem, dvd[XLEN-1]};
        diff      = shifted - {1'b0, dvs};
        q_fix     = q_neg ? -dvd : dvd;
        r_fix     = r_neg ? -rem : rem;
    end

    assign div_ready_o = (state == IDLE);
    assign res_valid_o = (state == DONE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            op    <= '0;
            op1   <= '0;
            op2   <= '0;
            dvd   <= '0;
            dvs   <= '0;
            rem   <= '0;
            cnt   <= '0;
            q_neg <= 1'b0;
            r_neg <= 1'b0;
            res_o <= '0;
        end else if (flush_i) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: if (div_valid_i) begin
                    op    <= div_op_i;
                    op1   <= div_op1_i;
                    op2   <= div_op2_i;
                    state <= PREP;
                end
                PREP: begin
                    dvd   <= abs1;
                    dvs   <= abs2;
                    rem   <= '0;
                    cnt   <= '0;
                    q_neg <= is_signed & (op1[XLEN-1] ^ op2[XLEN-1]);
                    r_neg <= is_signed & op1[XLEN-1];
                    if (div_zero) begin
                        res_o <= op[1] ? op1 : '1;
                        state <= DONE;
                    end else if (sgn_ovf) begin
                        res_o <= op[1] ? '0 : op1;
                        state <= DONE;
                    end else begin
                        state <= CALC;
                    end
                end
                CALC: begin
                    if (!diff[XLEN]) begin
                        rem <= diff[XLEN-1:0];
                        dvd <= {dvd[XLEN-2:0], 1'b1};
                    end else begin
                        rem <= shifted[XLEN-1:0];
                        dvd <= {dvd[XLEN-2:0], 1'b0};
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(XLEN - 1))
                        state <= FIX;
                end
                FIX: begin
                    res_o <= op[1] ? r_fix : q_fix;
                    state <= DONE;
                end
                DONE: if (res_ready_i)
                    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/rv_div.md
RV_DIV -- requirements
Module: rv_div

Interface
REQ-001 SHALL have parameter XLEN, default 64, operand/result width in bits (even, >=8).
REQ-002 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port div_valid_i  input  1  request valid.
REQ-005 SHALL have port div_ready_o  output  1  request ready; high only in IDLE.
REQ-006 SHALL have port div_op_i  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-007 SHALL have port div_op1_i  input  XLEN  dividend.
REQ-008 SHALL have port div_op2_i  input  XLEN  divisor.
REQ-009 SHALL have port flush_i  input  1  synchronous abort of an in-flight operation.
REQ-010 SHALL have port res_valid_o  output  1  result valid.
REQ-011 SHALL have port res_ready_i  input  1  result accepted by consumer.
REQ-012 SHALL have port res_o  output  XLEN  quotient or remainder per op.

Function
REQ-013 SHALL implement states IDLE, PREP, CALC, FIX, DONE; one operation in flight; no overlap.
REQ-014 SHALL accept a request at edge T0 when div_valid_i & div_ready_o; capture op, operands; IDLE->PREP.
REQ-015 PREP SHALL take absolute values for signed ops (DIV/REM), record quotient sign (op1[MSB]^op2[MSB]) and remainder sign (op1[MSB]).
REQ-016 PREP SHALL detect divisor==0: result = all-ones for DIV/DIVU, = dividend for REM/REMU; PREP->DONE at T0+1.
REQ-017 PREP SHALL detect signed overflow (DIV/REM, op1 = 2^(XLEN-1), op2 = all-ones): result = op1 for DIV, 0 for REM; PREP->DONE at T0+1.
REQ-018 Otherwise PREP->CALC at T0+1; iteration counter cleared to 0.
REQ-019 CALC SHALL perform restoring radix-2 division, one quotient bit per cycle MSB first, partial remainder XLEN+1 bits wide; exactly XLEN cycles; CALC->FIX at edge T0+XLEN+1.
REQ-020 FIX SHALL negate quotient if quotient sign set, negate remainder if remainder sign set (signed ops only), select quotient (DIV/DIVU) or remainder (REM/REMU); FIX->DONE at T0+XLEN+2.
REQ-021 Normal latency: res_valid_o high from edge T0+XLEN+2 (66 for XLEN=64); special cases: from edge T0+1.
REQ-022 DONE SHALL hold res_valid_o=1 and res_o stable until res_valid_o & res_ready_i; then DONE->IDLE at that edge.
REQ-023 res_o SHALL retain its last value after the result handshake until the next result is loaded.
REQ-024 div_ready_o SHALL be low in PREP, CALC, FIX, DONE; new request acceptable the cycle after result handshake at earliest.
REQ-025 flush_i high at an edge in PREP/CALC/FIX/DONE SHALL force IDLE, res_valid_o=0, no result; flush_i in IDLE SHALL be ignored and SHALL block acceptance that edge.
REQ-026 Results SHALL match RISC-V M semantics: quotient truncates toward zero; remainder sign follows dividend.

Reset
REQ-027 While rstn low: state IDLE, res_valid_o=0, res_o=0, div_ready_o=1, counter 0, internal registers 0.
REQ-028 Reset assertion mid-operation SHALL discard the operation immediately (asynchronously); no result produced after release.

Verification
REQ-029 DIVU 100/7 -> res_o=14, res_valid_o at T0+66; REMU same operands -> res_o=2.
REQ-030 DIV -7/2 -> 0xFFFF_FFFF_FFFF_FFFD; REM -7/2 -> 0xFFFF_FFFF_FFFF_FFFF; REM 7/-2 -> 1.
REQ-031 DIV 5/0 -> 0xFFFF_FFFF_FFFF_FFFF at T0+1; REMU 5/0 -> 5 at T0+1.
REQ-032 DIV 0x8000_0000_0000_0000 / 0xFFFF_FFFF_FFFF_FFFF -> 0x8000_0000_0000_0000 at T0+1; REM same -> 0.
REQ-033 res_ready_i low 10 cycles in DONE -> res_o/res_valid_o stable, div_ready_o=0; release -> IDLE next edge, div_ready_o=1.
REQ-034 flush_i at CALC iteration 20 -> IDLE next edge, no res_valid_o; rstn low mid-CALC -> res_valid_o=0, res_o=0, div_ready_o=1 without clock edge.
